bpc_symbol_encoder: RTL and testbench



---
 rtl/bpc_pkg.sv | 40 ++++
 rtl/bpc_symbol_classify.sv | 50 +++++
 rtl/bpc_symbol_encoder.sv | 188 ++++++++++++++++++
 tb/tb_bpc_symbol_encoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bpc_pkg.sv
// Shared constants, FSM state type and zero-run code helper for the BPC symbol encoder.
package bpc_pkg;

    localparam int BPC_PLANE_W   = 63;
    localparam int BPC_MAX_RUN   = 16;
    localparam int BPC_CODE_W    = 64;
    localparam int BPC_READY_MAX = 58;

    localparam logic [4:0] BPC_ALL1 = 5'b00000;
    localparam logic [4:0] BPC_DBP0 = 5'b00001;
    localparam logic [4:0] BPC_TWO1 = 5'b00010;
    localparam logic [4:0] BPC_ONE1 = 5'b00011;
    localparam logic [2:0] BPC_ZERO = 3'b001;
    localparam logic [1:0] BPC_RUN  = 2'b01;
    localparam logic [0:0] BPC_RAW  = 1'b1;

    typedef enum logic {
        ST_ACTIVE,
        ST_DRAIN
    } bpc_state_e;

    // Left-aligned flush code for a run of zero planes plus its length.
    typedef struct packed {
        logic [5:0] code;
        logic [2:0] len;
    } bpc_run_code_t;

    function automatic bpc_run_code_t bpc_run_code(input logic [4:0] run);
        bpc_run_code_t rc;
        if (run == 5'd1) begin
            rc.code = {BPC_ZERO, 3'b000};
            rc.len  = 3'd3;
        end else begin
            rc.code = {BPC_RUN, 4'(run - 5'd2)};
            rc.len  = 3'd6;
        end
        return rc;
    endfunction

endpackage

// File: rtl/bpc_symbol_classify.sv
// Combinational classifier: maps one DBX/DBP plane pair to a left-aligned BPC code.
// Zero planes return an empty code; the encoder decides how they are coded.
module bpc_symbol_classify
    import bpc_pkg::*;
(
    input  logic [BPC_PLANE_W-1:0] dbx,
    input  logic [BPC_PLANE_W-1:0] dbp,
    output logic [BPC_CODE_W-1:0]  code,
    output logic [6:0]             code_len,
    output logic                   is_zero
);

    logic [63:0] dbx_ext;
    logic [63:0] low_bit;
    logic [5:0]  low_idx;

    always_comb begin
        dbx_ext = {1'b0, dbx};
        // Isolate the lowest set bit; the spare top bit keeps a lone bit 62 from looking like a pair.
        low_bit = dbx_ext & (~dbx_ext + 64'd1);
        low_idx = '0;
        for (int i = BPC_PLANE_W - 1; i >= 0; i--) begin
            if (dbx[i]) begin
                low_idx = 6'(i);
            end
        end

        is_zero  = (dbx == '0);
        code     = {BPC_RAW, dbx};
        code_len = 7'd64;

        if (is_zero) begin
            code     = '0;
            code_len = '0;
        end else if (&dbx) begin
            code     = {BPC_ALL1, 59'd0};
            code_len = 7'd5;
        end else if (dbp == '0) begin
            code     = {BPC_DBP0, 59'd0};
            code_len = 7'd5;
        end else if (dbx_ext == (low_bit | (low_bit << 1))) begin
            code     = {BPC_TWO1, low_idx, 53'd0};
            code_len = 7'd11;
        end else if (dbx_ext == low_bit) begin
            code     = {BPC_ONE1, low_idx, 53'd0};
            code_len = 7'd11;
        end
    end

endmodule

// File: rtl/bpc_symbol_encoder.sv
// BPC symbol encoder: classifies planes and packs the code stream MSB-first into 32-bit words.
// Zero-run coding is enabled by defining BPC_ENC_ZRL_EN; otherwise each zero plane codes as 001.
module bpc_symbol_encoder
    import bpc_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int ACC_W = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BPC_PLANE_W-1:0] in_dbx,
    input  logic [BPC_PLANE_W-1:0] in_dbp,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [5:0]             out_bits,
    output logic                   out_last
);

    localparam logic [7:0] WORD_BITS = 8'(OUT_W);

    bpc_state_e          state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [7:0]          fill_q, fill_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic [5:0]          out_bits_q, out_bits_d;
    logic                out_last_q, out_last_d;

    logic [BPC_CODE_W-1:0] cls_code;
    logic [6:0]            cls_len;
    logic                  cls_zero;

    logic                accept;
    logic                slot_free;
    logic                draining;
    logic [ACC_W-1:0]    app_vec;
    logic [7:0]          app_len;
    logic [ACC_W-1:0]    acc_app;
    logic [7:0]          fill_app;

    bpc_symbol_classify u_classify (
        .dbx      (in_dbx),
        .dbp      (in_dbp),
        .code     (cls_code),
        .code_len (cls_len),
        .is_zero  (cls_zero)
    );

    assign in_ready  = (state_q == ST_ACTIVE) && (fill_q <= 8'(BPC_READY_MAX));
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid_q || out_ready;
    assign draining  = (state_q == ST_DRAIN) || (accept && in_last);
    assign acc_app   = acc_q | (app_vec >> fill_q);
    assign fill_app  = fill_q + app_len;

`ifdef BPC_ENC_ZRL_EN
    logic [4:0]    run_cnt_q, run_cnt_d;
    logic [4:0]    run_next;
    bpc_run_code_t flush;
    logic          sym_on;

    // A pending zero run is flushed ahead of the current symbol's code in the same append.
    always_comb begin
        flush     = '0;
        sym_on    = 1'b0;
        run_next  = run_cnt_q + 5'd1;
        run_cnt_d = run_cnt_q;
        if (accept) begin
            if (cls_zero) begin
                if (run_next == 5'(BPC_MAX_RUN) || in_last) begin
                    flush     = bpc_run_code(run_next);
                    run_cnt_d = '0;
                end else begin
                    run_cnt_d = run_next;
                end
            end else begin
                if (run_cnt_q != '0) begin
                    flush = bpc_run_code(run_cnt_q);
                end
                sym_on    = 1'b1;
                run_cnt_d = '0;
            end
        end
        app_vec = {flush.code, {(ACC_W-6){1'b0}}};
        app_len = {5'd0, flush.len};
        if (sym_on) begin
            app_vec = app_vec | ({cls_code, {(ACC_W-BPC_CODE_W){1'b0}}} >> flush.len);
            app_len = app_len + {1'b0, cls_len};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end
`else
    always_comb begin
        app_vec = '0;
        app_len = '0;
        if (accept) begin
            if (cls_zero) begin
                app_vec = {BPC_ZERO, {(ACC_W-3){1'b0}}};
                app_len = 8'd3;
            end else begin
                app_vec = {cls_code, {(ACC_W-BPC_CODE_W){1'b0}}};
                app_len = {1'b0, cls_len};
            end
        end
    end
`endif

    // Words are cut from the accumulator after this cycle's append, so accept and emit can overlap.
    // While draining, a remainder of 32 bits or less becomes the final word of the block.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_app;
        fill_d      = fill_app;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_bits_d  = out_bits_q;
        out_last_d  = out_last_q;

        if (slot_free) begin
            if ((fill_app > WORD_BITS) || ((fill_app == WORD_BITS) && !draining)) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_app[ACC_W-1 -: OUT_W];
                out_bits_d  = 6'(OUT_W);
                out_last_d  = 1'b0;
                acc_d       = acc_app << OUT_W;
                fill_d      = fill_app - WORD_BITS;
            end else if (draining && (fill_app != '0)) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_app[ACC_W-1 -: OUT_W];
                out_bits_d  = fill_app[5:0];
                out_last_d  = 1'b1;
                acc_d       = '0;
                fill_d      = '0;
            end
        end

        case (state_q)
            ST_ACTIVE: begin
                if (accept && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACTIVE;
            acc_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bits_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bits_q  <= out_bits_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bits  = out_bits_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_bpc_symbol_encoder.sv
// Self-checking bench for bpc_symbol_encoder: vector table, scoreboard of expected words,
// and hand-written sequences for zero runs, output backpressure and mid-block reset.
module tb_bpc_symbol_encoder;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  bits;
        logic        last;
    } word_t;

    typedef struct {
        logic [62:0] dbx;
        logic [62:0] dbp;
        logic [31:0] data;
        logic [5:0]  bits;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [62:0] in_dbx;
    logic [62:0] in_dbp;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_bits;
    logic        out_last;

    int    pass_cnt  = 0;
    int    total_cnt = 0;
    bit    bp_en     = 1'b0;
    word_t exp_q[$];
    word_t mon_exp;
    vec_t  vecs[10];

    bpc_symbol_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dbx    (in_dbx),
        .in_dbp    (in_dbp),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bits  (out_bits),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Random sink stalls, only while the vector table runs.
    always @(posedge clk) begin
        #1;
        if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: every accepted word is popped and compared against the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL unexpected_word: got data=%h bits=%0d last=%0d, required none",
                         out_data, out_bits, out_last);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_data, out_bits, out_last} === mon_exp) begin
                    pass_cnt++;
                end else begin
                    $display("[TB] FAIL word: got data=%h bits=%0d last=%0d, required data=%h bits=%0d last=%0d",
                             out_data, out_bits, out_last, mon_exp.data, mon_exp.bits, mon_exp.last);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic apply_stimulus(input logic [62:0] dbx, input logic [62:0] dbp, input logic last);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_dbx   = dbx;
        in_dbp   = dbp;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total_cnt++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] data, input logic [5:0] bits, input logic last);
        word_t w;
        w.data = data;
        w.bits = bits;
        w.last = last;
        exp_q.push_back(w);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("[TB] FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{63'h7FFF_FFFF_FFFF_FFFF, 63'h1, 32'h0000_0000, 6'd5};
        vecs[1] = '{63'h80, 63'h1, 32'h18E0_0000, 6'd11};
        vecs[2] = '{63'h30_0000, 63'h1, 32'h1280_0000, 6'd11};
        vecs[3] = '{63'h5, 63'h0, 32'h0800_0000, 6'd5};
        vecs[4] = '{63'h7FFF_FFFF_FFFF_FFFF, 63'h0, 32'h0000_0000, 6'd5};
        vecs[5] = '{63'h4000_0000_0000_0000, 63'h3, 32'h1FC0_0000, 6'd11};
        vecs[6] = '{63'h6000_0000_0000_0000, 63'h3, 32'h17A0_0000, 6'd11};
        vecs[7] = '{63'h1, 63'h9, 32'h1800_0000, 6'd11};
        vecs[8] = '{63'h3, 63'h9, 32'h1000_0000, 6'd11};
        vecs[9] = '{63'h0, 63'h0, 32'h2000_0000, 6'd3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_dbx    = '0;
        in_dbp    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check_output("reset_out_valid", 64'(out_valid), 64'd0);
        check_output("reset_out_data", 64'(out_data), 64'd0);
        check_output("reset_out_bits", 64'(out_bits), 64'd0);
        check_output("reset_out_last", 64'(out_last), 64'd0);
        check_output("reset_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] single-symbol blocks with random sink stalls");
        bp_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_word(vecs[i].data, vecs[i].bits, 1'b1);
            apply_stimulus(vecs[i].dbx, vecs[i].dbp, 1'b1);
        end
        wait_drain("table");
        bp_en = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;

        $display("[TB] five zero planes");
`ifdef BPC_ENC_ZRL_EN
        push_word(32'h4C00_0000, 6'd6, 1'b1);
`else
        push_word(32'h2492_0000, 6'd15, 1'b1);
`endif
        for (int i = 0; i < 5; i++) apply_stimulus('0, '0, (i == 4));
        wait_drain("zero5");

        $display("[TB] seventeen zero planes then a single one");
`ifdef BPC_ENC_ZRL_EN
        push_word(32'h788C_0000, 6'd20, 1'b1);
`else
        push_word(32'h2492_4924, 6'd32, 1'b0);
        push_word(32'h9249_2300, 6'd30, 1'b1);
`endif
        for (int i = 0; i < 17; i++) apply_stimulus('0, '0, 1'b0);
        apply_stimulus(63'h1, 63'h5, 1'b1);
        wait_drain("zero17");

        $display("[TB] raw plane under sink backpressure");
        out_ready = 1'b0;
        push_word(32'hD555_5555, 6'd32, 1'b0);
        push_word(32'h5555_5555, 6'd32, 1'b1);
        apply_stimulus(63'h5555_5555_5555_5555, 63'h1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("stall_in_ready", 64'(in_ready), 64'd0);
            check_output("stall_out_data", 64'({out_valid, out_data}), 64'h1_D555_5555);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain("raw");

        $display("[TB] reset pulse mid-block");
        out_ready = 1'b0;
        apply_stimulus(63'h0123_4567_89AB_CDEF, 63'h1, 1'b0);
        apply_stimulus('0, '0, 1'b0);
        apply_stimulus(63'h5, 63'h0, 1'b0);
        @(negedge clk);
        check_output("pre_reset_valid", 64'({out_valid, in_ready}), 64'h3);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_out_data", 64'(out_data), 64'd0);
        check_output("rst_out_bits", 64'(out_bits), 64'd0);
        check_output("rst_out_last", 64'(out_last), 64'd0);
        #10 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_output("post_reset_in_ready", 64'(in_ready), 64'd1);
        push_word(32'h0000_0000, 6'd5, 1'b1);
        apply_stimulus(63'h7FFF_FFFF_FFFF_FFFF, 63'h1, 1'b1);
        wait_drain("post_reset");

        check_output("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
